// File: rtl/sample_buffer_pkg.sv
// Shared widths and types for the circular sample capture buffer.
package sample_buffer_pkg;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/sample_buffer_if.sv
// Sample stream in, random-access readout and status out.
interface sample_buffer_if
  import sample_buffer_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
);
  logic          sample_valid;
  logic [DW-1:0] sample_in;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] sample_out;
  logic [AW-1:0] wr_ptr;
  logic          buf_full;

  modport master (
    output sample_valid,
    output sample_in,
    output read_addr,
    input  sample_out,
    input  wr_ptr,
    input  buf_full
  );

  modport slave (
    input  sample_valid,
    input  sample_in,
    input  read_addr,
    output sample_out,
    output wr_ptr,
    output buf_full
  );
endinterface

// File: rtl/sample_ram.sv
// Simple dual-port RAM, one write port, one registered read port.
// Read-first: a same-address read returns the pre-write contents.
module sample_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    rdata <= r_mem[raddr];
  end
endmodule

// File: rtl/sample_buffer.sv
// Circular capture buffer: free-running write pointer, sticky full,
// independent 1-cycle absolute-address read port.
module sample_buffer
  import sample_buffer_pkg::*;
#(
  parameter int DW    = DATA_W,
  parameter int DEPTH_P = DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  sample_buffer_if.slave  bus
);
  logic [AW-1:0] r_wr_ptr;
  logic          r_full;
  logic          r_out_clr;
  logic          w_we;
  logic [DW-1:0] w_rdata;

  assign w_we = bus.sample_valid & ~rst;

  sample_ram #(
    .DW    (DW),
    .DEPTH (DEPTH_P),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_wr_ptr),
    .wdata (bus.sample_in),
    .raddr (bus.read_addr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_full    <= 1'b0;
      r_out_clr <= 1'b1;
    end else begin
      r_out_clr <= 1'b0;
      if (bus.sample_valid) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_wr_ptr == AW'(DEPTH_P - 1)) begin
          r_full <= 1'b1;
        end
      end
    end
  end

  // Reset zeroes the output via a mux so the RAM keeps a plain read register.
  assign bus.sample_out = r_out_clr ? '0 : w_rdata;
  assign bus.wr_ptr     = r_wr_ptr;
  assign bus.buf_full   = r_full;
endmodule

// File: tb/tb_sample_buffer.sv
// Randomized scoreboard bench for sample_buffer against a memory-array model.
module tb_sample_buffer;
  import sample_buffer_pkg::*;

  typedef struct {
    bit      ck;
    sample_t out;
    addr_t   wp;
    bit      full;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sample_buffer_if bus ();

  sample_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t    q[$];
  int      total = 0;
  int      bad   = 0;
  sample_t mmem[DEPTH];
  bit      mknown[DEPTH];
  int      mwp = 0;
  int      nwr = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Drive one cycle, predict the state after the edge, return at edge+1.
  task automatic cyc(input bit r, input bit v, input sample_t d, input int a);
    exp_t e;
    rst              = r;
    bus.sample_valid = v;
    bus.sample_in    = d;
    bus.read_addr    = addr_t'(a);
    if (r) begin
      e.ck  = 1'b1;
      e.out = '0;
      mwp   = 0;
      nwr   = 0;
    end else begin
      e.ck  = mknown[a];
      e.out = mmem[a];
      if (v) begin
        mmem[mwp]   = d;
        mknown[mwp] = 1'b1;
        mwp         = (mwp + 1) % DEPTH;
        nwr++;
      end
    end
    e.wp   = addr_t'(mwp);
    e.full = (nwr >= DEPTH);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic sample_t rnd();
    return sample_t'($urandom);
  endfunction

  function automatic int ra();
    return int'($urandom_range(DEPTH - 1));
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        if (e.ck) chk("sb_out", 32'(bus.sample_out), 32'(e.out));
        chk("sb_wr_ptr", 32'(bus.wr_ptr), 32'(e.wp));
        chk("sb_full", 32'(bus.buf_full), 32'(e.full));
      end
    end
  end

  int wa[6] = '{0, 1, 2, 13, 14, 255};
  int wv[6] = '{256, 257, 258, 269, 14, 255};

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.read_addr    = '0;

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, rnd(), ra());
    chk("rst_out", 32'(bus.sample_out), 32'h0);
    chk("rst_ptr", 32'(bus.wr_ptr), 32'h0);
    chk("rst_full", 32'(bus.buf_full), 32'h0);

    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, sample_t'(i), ra());
    chk("fill_ptr", 32'(bus.wr_ptr), 32'd10);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, rnd(), i);
      chk("fill_rd", 32'(bus.sample_out), 32'(i));
    end

    cyc(1'b1, 1'b0, '0, 0);
    for (int i = 0; i < 270; i++) begin
      cyc(1'b0, 1'b1, sample_t'(i), ra());
      if (i == 254) chk("full_early", 32'(bus.buf_full), 32'h0);
      if (i == 255) chk("full_rise", 32'(bus.buf_full), 32'h1);
    end
    chk("wrap_ptr", 32'(bus.wr_ptr), 32'd14);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b0, rnd(), wa[k]);
      chk("wrap_rd", 32'(bus.sample_out), 32'(wv[k]));
    end

    for (int n = 0; n < 20; n++)
      cyc(1'b0, (n % 2) == 0, sample_t'(32'hA000 + n), ra());
    chk("gap_ptr", 32'(bus.wr_ptr), 32'd24);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, rnd(), 14 + k);
      chk("gap_rd", 32'(bus.sample_out), 32'hA000 + 2 * k);
    end

    cyc(1'b1, 1'b0, '0, 0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, sample_t'(i), ra());
    cyc(1'b1, 1'b0, '0, 0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, sample_t'(i), ra());
    cyc(1'b0, 1'b1, 16'h1234, 5);
    chk("coll_old", 32'(bus.sample_out), 32'h0005);
    cyc(1'b0, 1'b0, rnd(), 5);
    chk("coll_new", 32'(bus.sample_out), 32'h1234);

    cyc(1'b1, 1'b0, '0, 0);
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, sample_t'(i), ra());
    cyc(1'b1, 1'b1, 16'hDEAD, ra());
    chk("mid_ptr", 32'(bus.wr_ptr), 32'h0);
    chk("mid_full", 32'(bus.buf_full), 32'h0);
    cyc(1'b0, 1'b1, 16'hBEEF, 7);
    cyc(1'b0, 1'b0, rnd(), 0);
    chk("mid_a0", 32'(bus.sample_out), 32'hBEEF);
    cyc(1'b0, 1'b0, rnd(), 50);
    chk("mid_a50", 32'(bus.sample_out), 32'd50);

    for (int i = 0; i < 800; i++)
      cyc($urandom_range(63) == 0, $urandom_range(1) == 1, rnd(), ra());

    cyc(1'b0, 1'b0, '0, 0);
    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
